// File: rtl/pid.sv
// Incremental discrete PID controller: u[n] = u[n-1] + k1*e[n] + k2*e[n-1] + k3*e[n-2].
// Saturating arithmetic throughout; gains are signed fixed point with FRAC fractional bits.
module pid #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    srst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] reference,
  input  logic signed [WIDTH-1:0] feedback,
  input  logic signed [WIDTH-1:0] k1,
  input  logic signed [WIDTH-1:0] k2,
  input  logic signed [WIDTH-1:0] k3,
  output logic signed [WIDTH-1:0] control
);

  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]   error, error1, error2, control1;
  logic signed [WIDTH-1:0]   multiplied1, multiplied2, multiplied3;
  logic signed [WIDTH:0]     diff;
  logic signed [2*WIDTH-1:0] prod1, prod2, prod3;
  logic signed [2*WIDTH-1:0] shift1, shift2, shift3;
  logic signed [WIDTH+1:0]   sum;

  // Overflow is detected by the guard bits disagreeing with the result sign bit.
  function automatic logic signed [WIDTH-1:0] satDiff(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? MINW : MAXW;
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] satSum(input logic signed [WIDTH+1:0] v);
    if ((&v[WIDTH+1:WIDTH-1]) || !(|v[WIDTH+1:WIDTH-1])) return v[WIDTH-1:0];
    return v[WIDTH+1] ? MINW : MAXW;
  endfunction

  function automatic logic signed [WIDTH-1:0] satProd(input logic signed [2*WIDTH-1:0] v);
    if ((&v[2*WIDTH-1:WIDTH-1]) || !(|v[2*WIDTH-1:WIDTH-1])) return v[WIDTH-1:0];
    return v[2*WIDTH-1] ? MINW : MAXW;
  endfunction

  assign diff = {reference[WIDTH-1], reference} - {feedback[WIDTH-1], feedback};

  assign prod1 = $signed({{WIDTH{k1[WIDTH-1]}}, k1}) * $signed({{WIDTH{error[WIDTH-1]}}, error});
  assign prod2 = $signed({{WIDTH{k2[WIDTH-1]}}, k2}) * $signed({{WIDTH{error1[WIDTH-1]}}, error1});
  assign prod3 = $signed({{WIDTH{k3[WIDTH-1]}}, k3}) * $signed({{WIDTH{error2[WIDTH-1]}}, error2});

  // Arithmetic shift floors toward -inf, so -1.5 becomes -2.
  assign shift1 = prod1 >>> FRAC;
  assign shift2 = prod2 >>> FRAC;
  assign shift3 = prod3 >>> FRAC;

  assign multiplied1 = satProd(shift1);
  assign multiplied2 = satProd(shift2);
  assign multiplied3 = satProd(shift3);

  assign sum = {{2{control1[WIDTH-1]}}, control1}
             + {{2{multiplied1[WIDTH-1]}}, multiplied1}
             + {{2{multiplied2[WIDTH-1]}}, multiplied2}
             + {{2{multiplied3[WIDTH-1]}}, multiplied3};

  // Synchronous clear outranks the enable so a frozen controller can still be flushed.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      error    <= '0;
      error1   <= '0;
      error2   <= '0;
      control1 <= '0;
    end else if (!srst) begin
      error    <= '0;
      error1   <= '0;
      error2   <= '0;
      control1 <= '0;
    end else if (en) begin
      error    <= satDiff(diff);
      error1   <= error;
      error2   <= error1;
      control1 <= satSum(sum);
    end
  end

  assign control = control1;

endmodule

// File: tb/tb_pid.sv
// Self-checking bench for pid: integer reference model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_pid;
  localparam int W = 32;
  localparam int F = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic srst = 1'b1;
  logic en = 1'b0;
  logic signed [W-1:0] reference = '0;
  logic signed [W-1:0] feedback = '0;
  logic signed [W-1:0] k1 = '0;
  logic signed [W-1:0] k2 = '0;
  logic signed [W-1:0] k3 = '0;
  logic signed [W-1:0] control;

  int errors = 0;
  int checks = 0;
  longint me0 = 0, me1 = 0, me2 = 0, mu = 0, nu;

  pid #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .arst(arst), .srst(srst), .en(en),
    .reference(reference), .feedback(feedback),
    .k1(k1), .k2(k2), .k3(k3), .control(control)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input longint r, input longint f, input longint a,
                               input longint b, input longint c, input logic e, input logic s);
    reference = r[W-1:0];
    feedback  = f[W-1:0];
    k1 = a[W-1:0];
    k2 = b[W-1:0];
    k3 = c[W-1:0];
    en = e;
    srst = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseArst();
    arst = 1'b0;
    #1;
    checkOutput("arst_control_immediate", longint'(control), 0);
    checkOutput("arst_error_immediate", longint'(dut.error), 0);
    #1;
    arst = 1'b1;
  endtask

  // Reference model: the controller law evaluated in 64-bit integers with clamping.
  always @(posedge clk or negedge arst) begin
    if (!arst || !srst) begin
      me0 = 0; me1 = 0; me2 = 0; mu = 0;
    end else if (en) begin
      nu = clamp(mu + clamp((longint'(k1) * me0) >>> F)
                    + clamp((longint'(k2) * me1) >>> F)
                    + clamp((longint'(k3) * me2) >>> F));
      me2 = me1;
      me1 = me0;
      me0 = clamp(longint'(reference) - longint'(feedback));
      mu  = nu;
    end
  end

  always @(negedge clk) begin
    if (arst) begin
      checkOutput("model_control", longint'(control), mu);
      checkOutput("model_error", longint'(dut.error), me0);
    end
  end

  initial begin
    longint pexp[4] = '{0, 100, 200, 300};
    longint dexp[5] = '{0, 0, 10, 30, 30};
    #12;
    checkOutput("reset_control", longint'(control), 0);
    arst = 1'b1;

    // Proportional only
    for (int i = 0; i < 4; i++) begin
      applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
      checkOutput("p_only", longint'(control), pexp[i]);
    end

    // Delay line through k2/k3
    pulseArst();
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 0) ? 10 : 0, 0, 0, 65536, 131072, 1'b1, 1'b1);
      checkOutput("delay_line", longint'(control), dexp[i]);
    end

    // Fractional gain floors toward -inf
    pulseArst();
    applyStimulus(-3, 0, 32768, 0, 0, 1'b1, 1'b1);
    checkOutput("frac_mult1", longint'(dut.multiplied1), -2);
    checkOutput("frac_ctrl0", longint'(control), 0);
    applyStimulus(-3, 0, 32768, 0, 0, 1'b1, 1'b1);
    checkOutput("frac_ctrl1", longint'(control), -2);
    applyStimulus(-3, 0, 32768, 0, 0, 1'b1, 1'b1);
    checkOutput("frac_ctrl2", longint'(control), -4);

    // Positive saturation of error and control
    pulseArst();
    applyStimulus(64'sh7FFFFFFF, -1, 65536, 0, 0, 1'b1, 1'b1);
    checkOutput("sat_error", longint'(dut.error), 64'sh7FFFFFFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(64'sh7FFFFFFF, -1, 65536, 0, 0, 1'b1, 1'b1);
      checkOutput("sat_control", longint'(control), 64'sh7FFFFFFF);
    end

    // Enable freeze, synchronous clear, asynchronous clear
    pulseArst();
    applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
    applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
    checkOutput("en_pre", longint'(control), 100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(555, 7, 7, 99999, -99999, 1'b0, 1'b1);
      checkOutput("en_frozen", longint'(control), 100);
    end
    applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
    checkOutput("en_resume", longint'(control), 200);
    applyStimulus(100, 0, 65536, 0, 0, 1'b0, 1'b0);
    checkOutput("srst_control", longint'(control), 0);
    checkOutput("srst_error", longint'(dut.error), 0);
    checkOutput("srst_error1", longint'(dut.error1), 0);
    checkOutput("srst_error2", longint'(dut.error2), 0);
    applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
    checkOutput("post_srst0", longint'(control), 0);
    applyStimulus(100, 0, 65536, 0, 0, 1'b1, 1'b1);
    checkOutput("post_srst1", longint'(control), 100);
    pulseArst();

    // Mixed-sign gains changing every cycle, checked against the model
    for (int i = 0; i < 12; i++)
      applyStimulus(i * 37 - 200, (i % 3) * 15 - 20, 65536 - i * 9000,
                    -(i * 5000), i * 3000 + 123, 1'b1, 1'b1);

    // Negative saturation of error and products
    pulseArst();
    applyStimulus(-64'sh80000000, 1, 262144, 0, 0, 1'b1, 1'b1);
    checkOutput("negsat_error", longint'(dut.error), -64'sh80000000);
    checkOutput("negsat_mult1", longint'(dut.multiplied1), -64'sh80000000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(-64'sh80000000, 1, 262144, -65536, 65536, 1'b1, 1'b1);
      checkOutput("negsat_control", longint'(control), -64'sh80000000);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pid.md
PID -- requirements
Module: pid

Interface
REQ-001 Parameter WIDTH, default 32: data width of all data ports and internal registers.
REQ-002 Parameter FRAC, default 16: fractional bits of the gains k1/k2/k3, which are signed Qm.FRAC.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-low.
REQ-005 srst  input  1  synchronous clear, active-low.
REQ-006 en  input  1  clock enable; when low, all registers hold.
REQ-007 reference  input  WIDTH  signed setpoint.
REQ-008 feedback  input  WIDTH  signed measured value.
REQ-009 k1  input  WIDTH  signed gain applied to e[n].
REQ-010 k2  input  WIDTH  signed gain applied to e[n-1].
REQ-011 k3  input  WIDTH  signed gain applied to e[n-2].
REQ-012 control  output  WIDTH  signed controller output; registered.

Function
REQ-013 The block SHALL implement the incremental discrete PID u[n] = u[n-1] + k1*e[n] + k2*e[n-1] + k3*e[n-2].
REQ-014 Internal registers SHALL be named error, error1, error2 and control1; internal combinational products SHALL be named multiplied1, multiplied2 and multiplied3 (hierarchically probed).
REQ-015 On each rising edge with en=1 and srst=1, error SHALL load sat(reference - feedback), computed at WIDTH+1 bits and saturated to the signed WIDTH range.
REQ-016 On the same edge, error1 SHALL load the old error and error2 SHALL load the old error1.
REQ-017 multiplied1 = sat((k1*error) >>> FRAC), multiplied2 = sat((k2*error1) >>> FRAC), multiplied3 = sat((k3*error2) >>> FRAC).
REQ-018 Each product in REQ-017 SHALL be a full 2*WIDTH-bit signed product, arithmetically shifted (truncation toward -inf), then saturated to WIDTH bits.
REQ-019 control1 SHALL load sat(control1 + multiplied1 + multiplied2 + multiplied3), summed at WIDTH+2 bits and then saturated; control SHALL equal control1.
REQ-020 Saturation SHALL clamp to 2^(WIDTH-1)-1 and -2^(WIDTH-1); no wrap-around anywhere.
REQ-021 Latency: an input pair sampled at edge N SHALL first affect control at edge N+1.
REQ-022 With en=0, error, error1, error2 and control1 SHALL hold; gains and inputs are ignored.
REQ-023 Gains MAY change on any cycle; new gains take effect on the next enabled edge.

Reset
REQ-024 arst=0 SHALL immediately clear error, error1, error2 and control1 to 0, independent of clk and en.
REQ-025 srst=0 at a rising edge SHALL clear the same registers to 0; srst has priority over en.
REQ-026 After arst deasserts, the first enabled edge SHALL behave as in REQ-015 to REQ-019 with all history zero.
REQ-027 Reset asserted mid-operation SHALL discard all history; there is no partial state.

Verification
REQ-028 P-only test: k1=65536, k2=k3=0, reference=100, feedback=0, en=1 from reset. Required: control = 0, 100, 200, 300 after edges 1, 2, 3, 4.
REQ-029 Delay-line test: k1=0, k2=65536, k3=131072, single-cycle error pulse of 10 at edge 1, then 0. Required: control = 0, 0, 10, 30, 30 after edges 1 to 5.
REQ-030 Fractional gain test: k1=32768 (0.5), error=-3. Required: multiplied1 = -2 (floor); control decreases by 2 per cycle.
REQ-031 Saturation test: reference=0x7FFFFFFF, feedback=0xFFFFFFFF (-1), k1=65536. Required: error = 0x7FFFFFFF; control clamps at 0x7FFFFFFF and never wraps negative.
REQ-032 Enable and reset test: deassert en for 3 cycles. Required: control is frozen. Then pulse srst=0 for one edge. Required: all registers are 0 at that edge. Then pulse arst=0 between edges. Required: control is 0 immediately.
